// File: rtl/multi_digit_counter.sv
// Multi-digit up/down hex/BCD counter with selectable rate prescaler, parallel load,
// wrap pulse and per-digit active-low seven-segment decode. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module multi_digit_counter #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned DIV_WIDTH = 32,
    parameter int unsigned RATE0     = 1,
    parameter int unsigned RATE1     = 50000000,
    parameter int unsigned RATE2     = 25000000,
    parameter int unsigned RATE3     = 12500000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  bcd,
    input  logic [1:0]            rate_sel,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic [7*DIGITS-1:0]   segments,
    output logic                  wrap
);

    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned SW = 7 * DIGITS;

    logic [DIV_WIDTH-1:0] prescaler;
    logic [DIV_WIDTH-1:0] rate_m1;
    logic                 tick;
    logic [CW-1:0]        count_next;
    logic [CW-1:0]        load_clamped;
    logic                 wrap_next;
    logic [3:0]           max_digit;
    logic [3:0]           digit;
    logic                 carry;
    logic                 borrow;
    logic                 all_max;
    logic                 all_zero;

    // Terminal prescaler value for the selected rate
    always_comb begin
        rate_m1 = DIV_WIDTH'(RATE0 - 1);
        case (rate_sel)
            2'd0:    rate_m1 = DIV_WIDTH'(RATE0 - 1);
            2'd1:    rate_m1 = DIV_WIDTH'(RATE1 - 1);
            2'd2:    rate_m1 = DIV_WIDTH'(RATE2 - 1);
            default: rate_m1 = DIV_WIDTH'(RATE3 - 1);
        endcase
    end

    // >= so that switching to a shorter rate ticks immediately
    assign tick = run && (prescaler >= rate_m1);

    // Load data, with decimal digits above 9 clamped to 9
    always_comb begin
        load_clamped = load_value;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd && (load_value[4*i +: 4] > 4'd9)) begin
                load_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    // Ripple carry/borrow across digits; carry and borrow mean "all lower digits at the limit"
    always_comb begin
        max_digit  = bcd ? 4'd9 : 4'd15;
        count_next = count;
        digit      = '0;
        carry      = 1'b1;
        borrow     = 1'b1;
        all_max    = 1'b1;
        all_zero   = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit = count[4*i +: 4];
            if (up) begin
                if (carry) begin
                    count_next[4*i +: 4] = (digit >= max_digit) ? 4'd0 : digit + 4'd1;
                end
            end else begin
                if (borrow) begin
                    if (digit == 4'd0) begin
                        count_next[4*i +: 4] = max_digit;
                    end else if (bcd && (digit > 4'd9)) begin
                        count_next[4*i +: 4] = 4'd9;
                    end else begin
                        count_next[4*i +: 4] = digit - 4'd1;
                    end
                end
            end
            carry    = carry && (digit >= max_digit);
            borrow   = borrow && (digit == 4'd0);
            all_max  = all_max && (digit >= max_digit);
            all_zero = all_zero && (digit == 4'd0);
        end
        wrap_next = up ? all_max : all_zero;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
            count     <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            prescaler <= '0;
            count     <= load_clamped;
            wrap      <= 1'b0;
        end else if (tick) begin
            prescaler <= '0;
            count     <= count_next;
            wrap      <= wrap_next;
        end else begin
            if (run) begin
                prescaler <= prescaler + DIV_WIDTH'(1);
            end
            wrap <= 1'b0;
        end
    end

    // Active-high gfedcba pattern inverted for common-anode displays
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] lit;
        case (d)
            4'h0:    lit = 7'h3F;
            4'h1:    lit = 7'h06;
            4'h2:    lit = 7'h5B;
            4'h3:    lit = 7'h4F;
            4'h4:    lit = 7'h66;
            4'h5:    lit = 7'h6D;
            4'h6:    lit = 7'h7D;
            4'h7:    lit = 7'h07;
            4'h8:    lit = 7'h7F;
            4'h9:    lit = 7'h6F;
            4'hA:    lit = 7'h77;
            4'hB:    lit = 7'h7C;
            4'hC:    lit = 7'h58;
            4'hD:    lit = 7'h5E;
            4'hE:    lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return ~lit;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic zero_above;
`endif

    always_comb begin
        segments = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            segments[7*i +: 7] = glyph(count[4*i +: 4]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; digit 0 always stays lit
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            zero_above = zero_above && (count[4*i +: 4] == 4'd0);
            if (zero_above) begin
                segments[7*i +: 7] = 7'h7F;
            end
        end
`endif
    end

    logic unused_sw;
    assign unused_sw = (SW == 0);

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench for multi_digit_counter: arithmetic reference model compared every cycle
// plus directed literal checks of the documented scenarios.
module tb_multi_digit_counter;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned CW     = 4 * DIGITS;
    localparam int unsigned SW     = 7 * DIGITS;
    localparam int R0 = 1;
    localparam int R1 = 5;
    localparam int R2 = 7;
    localparam int R3 = 200;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    logic          clock;
    logic          reset_n;
    logic          run;
    logic          up;
    logic          bcd;
    logic [1:0]    rate_sel;
    logic          load;
    logic [CW-1:0] load_value;
    logic [CW-1:0] count;
    logic [SW-1:0] segments;
    logic          wrap;

    int total = 0;
    int bad = 0;
    int wrap_seen = 0;
    bit checking = 0;

    logic [CW-1:0] m_count;
    logic          m_wrap;
    int            m_pre;

    multi_digit_counter #(
        .DIGITS(DIGITS), .DIV_WIDTH(32),
        .RATE0(R0), .RATE1(R1), .RATE2(R2), .RATE3(R3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .run(run), .up(up), .bcd(bcd),
        .rate_sel(rate_sel), .load(load), .load_value(load_value),
        .count(count), .segments(segments), .wrap(wrap)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rate_of(input logic [1:0] s);
        case (s)
            2'd0:    return R0;
            2'd1:    return R1;
            2'd2:    return R2;
            default: return R3;
        endcase
    endfunction

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, input logic b);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (b && (v[4*i +: 4] > 4'd9)) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Counting as modular arithmetic on the whole value; out-of-range decimal digits handled digit by digit
    function automatic logic [CW:0] model_step(input logic [CW-1:0] c, input logic u, input logic b);
        longint base, top, v;
        bit valid, w;
        logic [CW-1:0] r;
        base = b ? 10 : 16;
        top = 1;
        v = 0;
        valid = 1;
        w = 0;
        r = c;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (longint'(c[4*i +: 4]) >= base) valid = 0;
            v = v * base + longint'(c[4*i +: 4]);
            top = top * base;
        end
        if (valid) begin
            if (u) begin
                w = (v == top - 1);
                v = (v + 1) % top;
            end else begin
                w = (v == 0);
                v = (v + top - 1) % top;
            end
            for (int i = 0; i < int'(DIGITS); i++) begin
                r[4*i +: 4] = 4'(v % base);
                v = v / base;
            end
        end else if (u) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (c[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
                else begin
                    r[4*i +: 4] = c[4*i +: 4] + 4'd1;
                    break;
                end
            end
            w = 1;
            for (int i = 0; i < int'(DIGITS); i++) if (c[4*i +: 4] < 4'd9) w = 0;
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (c[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                else begin
                    r[4*i +: 4] = (c[4*i +: 4] > 4'd9) ? 4'd9 : c[4*i +: 4] - 4'd1;
                    break;
                end
            end
        end
        return {w, r};
    endfunction

    function automatic logic [SW-1:0] model_seg(input logic [CW-1:0] c);
        logic [SW-1:0] s;
        for (int i = 0; i < int'(DIGITS); i++) s[7*i +: 7] = GLYPH[c[4*i +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < int'(DIGITS); i++) begin
            if ((c >> (4*i)) == '0) s[7*i +: 7] = 7'h7F;
        end
`endif
        return s;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_count <= '0;
            m_wrap  <= 1'b0;
            m_pre   <= 0;
        end else if (load) begin
            m_count <= clamp(load_value, bcd);
            m_wrap  <= 1'b0;
            m_pre   <= 0;
        end else if (run && (m_pre >= rate_of(rate_sel) - 1)) begin
            {m_wrap, m_count} <= model_step(m_count, up, bcd);
            m_pre <= 0;
        end else begin
            m_wrap <= 1'b0;
            if (run) m_pre <= m_pre + 1;
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            check("model_count", 64'(count), 64'(m_count));
            check("model_wrap", 64'(wrap), 64'(m_wrap));
            check("model_segments", 64'(segments), 64'(model_seg(m_count)));
            if (wrap === 1'b1) wrap_seen++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [SW-1:0] seg_zero;

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        seg_zero = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        seg_zero = {7'h40, 7'h40, 7'h40, 7'h40};
`endif
        reset_n = 1'b0; run = 1'b0; up = 1'b1; bcd = 1'b1; rate_sel = 2'd0;
        load = 1'b0; load_value = '0;
        cycles(2);
        checking = 1;
        check("reset_count", 64'(count), 64'h0);
        check("reset_wrap", 64'(wrap), 64'h0);
        check("reset_segments", 64'(segments), 64'(seg_zero));

        // BCD up at one step per clock
        reset_n = 1'b1; run = 1'b1; wrap_seen = 0;
        cycles(10);
        check("bcd_10_ticks", 64'(count), 64'h0010);
        cycles(9990);
        check("bcd_wrap_count", 64'(count), 64'h0000);
        check("bcd_wrap_pulse", 64'(wrap), 64'h1);
        #1 check("bcd_single_wrap", 64'(wrap_seen), 64'd1);
        cycles(1);
        check("bcd_after_wrap", 64'(count), 64'h0001);
        check("bcd_wrap_low", 64'(wrap), 64'h0);
        run = 1'b0;

        // Hex down through zero
        bcd = 1'b0; up = 1'b0; load = 1'b1; load_value = 16'h0000;
        cycles(1);
        load = 1'b0; run = 1'b1;
        cycles(1);
        check("hex_down_wrap_count", 64'(count), 64'hFFFF);
        check("hex_down_wrap", 64'(wrap), 64'h1);
        cycles(1);
        check("hex_down_next", 64'(count), 64'hFFFE);
        check("hex_down_wrap_low", 64'(wrap), 64'h0);
        run = 1'b0;

        // Rate 5 with a 3-clock pause
        rate_sel = 2'd1; bcd = 1'b1; up = 1'b1; load = 1'b1; load_value = 16'h0000;
        cycles(1);
        load = 1'b0; run = 1'b1;
        cycles(4);
        check("rate5_before_step", 64'(count), 64'h0000);
        cycles(1);
        check("rate5_first_step", 64'(count), 64'h0001);
        cycles(2);
        run = 1'b0;
        cycles(3);
        run = 1'b1;
        cycles(2);
        check("rate5_paused_hold", 64'(count), 64'h0001);
        cycles(1);
        check("rate5_delayed_step", 64'(count), 64'h0002);
        run = 1'b0;

        // BCD clamp on load, and load beating a tick
        rate_sel = 2'd0; load = 1'b1; load_value = 16'h00AF; run = 1'b1;
        cycles(1);
        check("load_clamp", 64'(count), 64'h0099);
        check("load_clamp_seg0", 64'(segments[6:0]), 64'h10);
        load = 1'b0;
        cycles(1);
        check("after_load_step", 64'(count), 64'h0100);
        run = 1'b0;

        // Shorter rate selected mid-period
        rate_sel = 2'd3; bcd = 1'b0; up = 1'b1; load = 1'b1; load_value = 16'h0000;
        cycles(1);
        load = 1'b0; run = 1'b1;
        cycles(100);
        check("rate3_no_step", 64'(count), 64'h0000);
        rate_sel = 2'd0;
        cycles(1);
        check("rate_switch_tick", 64'(count), 64'h0001);
        rate_sel = 2'd3;
        cycles(199);
        check("rate3_from_zero_hold", 64'(count), 64'h0001);
        cycles(1);
        check("rate3_from_zero_step", 64'(count), 64'h0002);
        run = 1'b0;

        // Hex digits seen in BCD mode
        rate_sel = 2'd0; load = 1'b1; load_value = 16'h000C;
        cycles(1);
        load = 1'b0; bcd = 1'b1; up = 1'b0; run = 1'b1;
        cycles(1);
        check("bcd_over9_down", 64'(count), 64'h0009);
        run = 1'b0; bcd = 1'b0; load = 1'b1; load_value = 16'h00A9;
        cycles(1);
        load = 1'b0; bcd = 1'b1; up = 1'b1; run = 1'b1;
        cycles(1);
        check("bcd_over9_up", 64'(count), 64'h0100);
        run = 1'b0;

        // Asynchronous reset in the middle of a clock phase
        load = 1'b1; load_value = 16'h1234;
        cycles(1);
        load = 1'b0;
        check("preload_1234", 64'(count), 64'h1234);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_count", 64'(count), 64'h0);
        check("async_reset_wrap", 64'(wrap), 64'h0);
        check("async_reset_segments", 64'(segments), 64'(seg_zero));
        cycles(1);
        reset_n = 1'b1;
        cycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
